// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: hold, bubble, negedge shadow copy,
// forwarding-hit detection and saturating stall/flush event counters.
module pipe_stage_reg #(
  parameter int DATA_W   = 64,
  parameter int NDATA    = 3,
  parameter int CTRL_W   = 4,
  parameter int RADDR_W  = 5,
  parameter int ZERO_REG = 31,
  parameter int SHADOW   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [CTRL_W-1:0]         ctrl_in,
  input  logic                      regwrite_in,
  input  logic [RADDR_W-1:0]        rd_in,
  input  logic [NDATA*DATA_W-1:0]   data_in,
  output logic                      valid_out,
  output logic [CTRL_W-1:0]         ctrl_out,
  output logic                      regwrite_out,
  output logic [RADDR_W-1:0]        rd_out,
  output logic [NDATA*DATA_W-1:0]   data_out,
  output logic                      valid_sh,
  output logic                      regwrite_sh,
  output logic [RADDR_W-1:0]        rd_sh,
  output logic [NDATA*DATA_W-1:0]   data_sh,
  input  logic [RADDR_W-1:0]        rs_a,
  input  logic [RADDR_W-1:0]        rs_b,
  output logic                      hit_a,
  output logic                      hit_b,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int DW = NDATA * DATA_W;
  localparam logic [RADDR_W-1:0] ZR = RADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic               valid;
    logic [CTRL_W-1:0]  ctrl;
    logic               regwrite;
    logic [RADDR_W-1:0] rd;
    logic [DW-1:0]      data;
  } st_t;

  // Shadow carries no control vector: the register file never needs it.
  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic [RADDR_W-1:0] rd;
    logic [DW-1:0]      data;
  } sh_t;

  st_t cur;
  st_t nxt;
  st_t in_bus;
  sh_t sh;
  sh_t nxt_sh;
  sh_t cur_sh;

  assign in_bus = {valid_in, ctrl_in, regwrite_in, rd_in, data_in};

  always_comb begin
    nxt = cur;
    if (flush)
      nxt = '0;
    else if (!stall)
      nxt = in_bus;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cur <= '0;
    else
      cur <= nxt;
  end

  assign nxt_sh = {nxt.valid, nxt.regwrite, nxt.rd, nxt.data};
  assign cur_sh = {cur.valid, cur.regwrite, cur.rd, cur.data};

  generate
    if (SHADOW != 0) begin : g_shadow
      always_ff @(negedge clk or negedge reset) begin
        if (!reset)
          sh <= '0;
        else
          sh <= nxt_sh;
      end
    end else begin : g_noshadow
      assign sh = cur_sh;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush && flush_cnt != CMAX)
        flush_cnt <= flush_cnt + 1'b1;
      if (stall && !flush && stall_cnt != CMAX)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign valid_out    = cur.valid;
  assign ctrl_out     = cur.ctrl;
  assign regwrite_out = cur.regwrite;
  assign rd_out       = cur.rd;
  assign data_out     = cur.data;

  assign valid_sh    = sh.valid;
  assign regwrite_sh = sh.regwrite;
  assign rd_sh       = sh.rd;
  assign data_sh     = sh.data;

  assign hit_a = cur.valid & cur.regwrite
               & (cur.rd == rs_a) & (cur.rd != ZR);
  assign hit_b = cur.valid & cur.regwrite
               & (cur.rd == rs_b) & (cur.rd != ZR);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: random stimulus against a state-level model,
// one shadowed instance (CNT_W=4) and one unshadowed instance.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int ND = 3;
  localparam int CW = 4;
  localparam int RW = 5;
  localparam int BW = DW * ND;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          valid_in = 1'b0;
  logic [CW-1:0] ctrl_in = '0;
  logic          regwrite_in = 1'b0;
  logic [RW-1:0] rd_in = '0;
  logic [BW-1:0] data_in = '0;
  logic [RW-1:0] rs_a = '0;
  logic [RW-1:0] rs_b = '0;

  logic          valid_out_a, regwrite_out_a, valid_sh_a, regwrite_sh_a;
  logic [CW-1:0] ctrl_out_a;
  logic [RW-1:0] rd_out_a, rd_sh_a;
  logic [BW-1:0] data_out_a, data_sh_a;
  logic          hit_a_a, hit_b_a;
  logic [3:0]    stall_cnt_a, flush_cnt_a;

  logic          valid_out_b, regwrite_out_b, valid_sh_b, regwrite_sh_b;
  logic [CW-1:0] ctrl_out_b;
  logic [RW-1:0] rd_out_b, rd_sh_b;
  logic [BW-1:0] data_out_b, data_sh_b;
  logic          hit_a_b, hit_b_b;
  logic [15:0]   stall_cnt_b, flush_cnt_b;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SHADOW(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .ctrl_in(ctrl_in),
    .regwrite_in(regwrite_in), .rd_in(rd_in), .data_in(data_in),
    .valid_out(valid_out_a), .ctrl_out(ctrl_out_a),
    .regwrite_out(regwrite_out_a), .rd_out(rd_out_a),
    .data_out(data_out_a), .valid_sh(valid_sh_a),
    .regwrite_sh(regwrite_sh_a), .rd_sh(rd_sh_a),
    .data_sh(data_sh_a), .rs_a(rs_a), .rs_b(rs_b),
    .hit_a(hit_a_a), .hit_b(hit_b_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_stage_reg #(.SHADOW(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .ctrl_in(ctrl_in),
    .regwrite_in(regwrite_in), .rd_in(rd_in), .data_in(data_in),
    .valid_out(valid_out_b), .ctrl_out(ctrl_out_b),
    .regwrite_out(regwrite_out_b), .rd_out(rd_out_b),
    .data_out(data_out_b), .valid_sh(valid_sh_b),
    .regwrite_sh(regwrite_sh_b), .rd_sh(rd_sh_b),
    .data_sh(data_sh_b), .rs_a(rs_a), .rs_b(rs_b),
    .hit_a(hit_a_b), .hit_b(hit_b_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic          rw;
    logic [RW-1:0] rd;
    logic [BW-1:0] d;
  } st_t;

  st_t cur = '0;
  int  sc = 0;
  int  fc = 0;
  int  errs = 0;
  int  checks = 0;
  logic [RW-1:0] neg_rd_sh, neg_rd_out;

  // Callers must not move inputs between the negedge and the posedge.
  wire [BW+RW+CW+3:0] ins =
    {stall, flush, valid_in, ctrl_in, regwrite_in, rd_in, data_in};
  logic [BW+RW+CW+3:0] snap = '0;
  bit snap_ok = 1'b0;

  always @(negedge clk) begin
    snap    <= ins;
    snap_ok <= 1'b1;
  end

  always @(posedge clk)
    if (snap_ok && reset)
      assert (ins == snap)
      else $error("FAIL input_stable got=%0h exp=%0h", ins, snap);

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic st_t next_of();
    st_t n;
    if (flush)      n = '0;
    else if (stall) n = cur;
    else            n = {valid_in, ctrl_in, regwrite_in, rd_in, data_in};
    return n;
  endfunction

  function automatic logic hit(logic [RW-1:0] rs);
    return cur.v && cur.rw && (cur.rd == rs) && (cur.rd != 5'd31);
  endfunction

  task automatic check_all(string ph);
    chk({ph, "_out_a"}, 256'({valid_out_a, ctrl_out_a, regwrite_out_a,
        rd_out_a, data_out_a}), 256'(cur));
    chk({ph, "_out_b"}, 256'({valid_out_b, ctrl_out_b, regwrite_out_b,
        rd_out_b, data_out_b}), 256'(cur));
    chk({ph, "_sh_b"}, 256'({valid_sh_b, regwrite_sh_b, rd_sh_b,
        data_sh_b}), 256'({cur.v, cur.rw, cur.rd, cur.d}));
    chk({ph, "_hits_a"}, 256'({hit_a_a, hit_b_a}),
        256'({hit(rs_a), hit(rs_b)}));
    chk({ph, "_hits_b"}, 256'({hit_a_b, hit_b_b}),
        256'({hit(rs_a), hit(rs_b)}));
    chk({ph, "_scnt_a"}, 256'(stall_cnt_a), 256'((sc > 15) ? 15 : sc));
    chk({ph, "_fcnt_a"}, 256'(flush_cnt_a), 256'((fc > 15) ? 15 : fc));
    chk({ph, "_scnt_b"}, 256'(stall_cnt_b), 256'(sc));
    chk({ph, "_fcnt_b"}, 256'(flush_cnt_b), 256'(fc));
  endtask

  task automatic step();
    st_t n;
    @(negedge clk);
    #1;
    n = next_of();
    neg_rd_sh  = rd_sh_a;
    neg_rd_out = rd_out_a;
    chk("neg_sh_a", 256'({valid_sh_a, regwrite_sh_a, rd_sh_a, data_sh_a}),
        256'({n.v, n.rw, n.rd, n.d}));
    check_all("neg");
    @(posedge clk);
    cur = n;
    if (flush)      fc++;
    else if (stall) sc++;
    #1;
    check_all("pos");
  endtask

  task automatic randin();
    valid_in    = 1'($urandom);
    ctrl_in     = CW'($urandom);
    regwrite_in = 1'($urandom);
    rd_in       = ($urandom_range(0, 7) == 0) ? 5'd31 : RW'($urandom);
    data_in     = {$urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom};
    stall       = ($urandom_range(0, 3) == 0);
    flush       = ($urandom_range(0, 7) == 0);
    rs_a        = ($urandom_range(0, 1) == 0) ? rd_in : RW'($urandom);
    rs_b        = ($urandom_range(0, 2) == 0) ? rd_in : RW'($urandom);
  endtask

  st_t held;

  initial begin
    randin();
    #3;
    check_all("rst0");
    chk("rst0_sh_a", 256'({valid_sh_a, regwrite_sh_a, rd_sh_a,
        data_sh_a}), 256'(0));

    @(posedge clk);
    #4;
    stall = 1'b0; flush = 1'b0;
    valid_in = 1'b1; regwrite_in = 1'b1; rd_in = 5'd5;
    data_in = '0; data_in[63:0] = 64'hDEAD;
    reset = 1'b1;
    step();
    chk("load_rd5", 256'(rd_out_a), 256'(5));
    chk("load_dead", 256'(data_out_a[63:0]), 256'(64'hDEAD));

    rd_in = 5'd7;
    data_in = '0; data_in[127:64] = 64'h1234;
    step();
    chk("lead_sh_rd", 256'(neg_rd_sh), 256'(7));
    chk("lead_out_old", 256'(neg_rd_out), 256'(5));
    chk("lead_out_new", 256'(rd_out_a), 256'(7));
    chk("lead_sh_ch1", 256'(data_sh_a[127:64]), 256'(64'h1234));

    held = cur;
    repeat (3) begin
      randin();
      stall = 1'b1; flush = 1'b0;
      step();
    end
    chk("stall_hold", 256'({valid_out_a, ctrl_out_a, regwrite_out_a,
        rd_out_a, data_out_a}), 256'(held));
    chk("stall_sh", 256'(rd_sh_a), 256'(held.rd));
    chk("stall_cnt3", 256'(stall_cnt_a), 256'(3));

    randin();
    valid_in = 1'b1; regwrite_in = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_v", 256'({valid_out_a, regwrite_out_a}), 256'(0));
    chk("flush_d", 256'(data_out_a), 256'(0));
    chk("flush_cnt", 256'(flush_cnt_a), 256'(1));
    chk("flush_scnt", 256'(stall_cnt_a), 256'(3));

    stall = 1'b0; flush = 1'b0;
    valid_in = 1'b1; regwrite_in = 1'b1; rd_in = 5'd3;
    step();
    rs_a = 5'd3; rs_b = 5'd4;
    #1;
    chk("fwd_hit", 256'({hit_a_a, hit_b_a}), 256'(2'b10));
    rd_in = 5'd31;
    step();
    rs_a = 5'd31;
    #1;
    chk("fwd_xzr", 256'(hit_a_a), 256'(0));
    rd_in = 5'd3; regwrite_in = 1'b0;
    step();
    rs_a = 5'd3;
    #1;
    chk("fwd_norw", 256'(hit_a_a), 256'(0));

    repeat (300) begin
      randin();
      step();
    end

    @(posedge clk);
    #2;
    reset = 1'b0;
    cur = '0; sc = 0; fc = 0;
    #1;
    check_all("rstp");
    chk("rstp_sh_a", 256'({valid_sh_a, regwrite_sh_a, rd_sh_a,
        data_sh_a}), 256'(0));
    #1;
    reset = 1'b1;

    repeat (20) begin
      randin();
      stall = 1'b1; flush = 1'b0;
      step();
    end
    chk("sat_a", 256'(stall_cnt_a), 256'(15));
    chk("sat_b", 256'(stall_cnt_b), 256'(20));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
